halt_resume_ctrl: RTL

Debug run-control block that receives the halt request raised on EBREAK and takes the pipeline from halted back to running. It freezes fetch, drains older instructions and captures the halt PC. It then accepts resume or single-step commands over a valid/ready handshake from the debug port (FPGA buttons or the testbench). On resume it redirects fetch past the halting instruction.

---
 rtl/halt_resume_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/halt_resume_ctrl.sv
// rtl/halt_resume_ctrl.sv - debug halt/drain/resume run-control with optional single-step
// Optional feature macro: DEBUG_STEP_EN (single-step support); undefined builds treat every command as continue.
module halt_resume_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_req,
  input  logic [31:0]        halt_pc,
  input  logic               resume_valid,
  input  logic               resume_step,
  output logic               resume_ready,
  output logic               pipe_stall,
  output logic               pipe_flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               halted,
  output logic [31:0]        dpc,
  output logic [COUNT_W-1:0] halt_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic        handshake;
  logic        do_step;
  logic [31:0] dpc_next;

`ifdef DEBUG_STEP_EN
  assign do_step = resume_step;
`else
  logic unused_step;
  assign do_step     = 1'b0;
  assign unused_step = resume_step;
`endif

  // resume_ready is only ever high while in HALTED, so it alone qualifies the handshake
  assign handshake      = resume_valid & resume_ready;
  assign dpc_next       = dpc + 32'd4;
  assign redirect_valid = handshake;
  assign redirect_pc    = handshake ? dpc_next : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      drain_cnt    <= 4'd0;
      pipe_stall   <= 1'b0;
      pipe_flush   <= 1'b0;
      halted       <= 1'b0;
      resume_ready <= 1'b0;
      dpc          <= 32'd0;
      halt_count   <= '0;
    end else begin
      pipe_flush <= 1'b0;
      case (state)
        RUN: begin
          if (halt_req) begin
            dpc        <= halt_pc;
            drain_cnt  <= DRAIN_LOAD;
            pipe_stall <= 1'b1;
            pipe_flush <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) begin
            state        <= HALTED;
            halted       <= 1'b1;
            resume_ready <= 1'b1;
            if (halt_count != '1)
              halt_count <= halt_count + 1'b1;
          end
        end
        HALTED: begin
          if (handshake) begin
            dpc          <= dpc_next;
            halted       <= 1'b0;
            resume_ready <= 1'b0;
            pipe_stall   <= 1'b0;
            state        <= do_step ? STEP : RUN;
          end
        end
`ifdef DEBUG_STEP_EN
        STEP: begin
          // one unstalled cycle lets exactly one instruction in; no flush so it retires
          drain_cnt  <= DRAIN_LOAD;
          pipe_stall <= 1'b1;
          state      <= DRAIN;
        end
`endif
        default: begin
          state      <= RUN;
          pipe_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
